// File: rtl/dmem_responder_pkg.sv
//------------------------------------------------------------------------------
// Module : dmem_responder_pkg
// Brief  : Shared types for the LC-3b data-port responder and its word array.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package dmem_responder_pkg;

    typedef logic [15:0] lc3b_word;
    typedef logic [1:0]  lc3b_mem_wmask;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

    // Lane 0 covers [7:0], lane 1 covers [15:8].
    function automatic lc3b_word apply_wmask(
        input lc3b_word      old_word,
        input lc3b_word      new_word,
        input lc3b_mem_wmask mask
    );
        lc3b_word merged;
        merged        = old_word;
        if (mask[0]) merged[7:0]  = new_word[7:0];
        if (mask[1]) merged[15:8] = new_word[15:8];
        return merged;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
//------------------------------------------------------------------------------
// Module : dmem_array
// Brief  : Word array with combinational read and byte-masked synchronous write.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_array
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_we,
    input  lc3b_mem_wmask i_wmask,
    input  logic [AW-1:0] i_waddr,
    input  lc3b_word      i_wdata,
    input  logic [AW-1:0] i_raddr,
    output lc3b_word      o_rdata
);

    lc3b_word r_mem [DEPTH_WORDS];

    // Contents are deliberately not reset; preload happens through load_word.
    always @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= apply_wmask(r_mem[i_waddr], i_wdata, i_wmask);
        end
    end

    assign o_rdata = r_mem[i_raddr];

    task automatic load_word(input int unsigned idx, input lc3b_word data);
        r_mem[idx[AW-1:0]] <= data;
    endtask

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
//------------------------------------------------------------------------------
// Module : dmem_responder
// Brief  : Fixed-latency memory responder for the LC-3b MEM-stage data port.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int DEPTH_WORDS = 256
) (
    input  logic          clk,
    input  logic          reset,
    input  lc3b_word      mem_address,
    input  logic          mem_read,
    input  logic          mem_write,
    input  lc3b_mem_wmask mem_byte_enable,
    input  lc3b_word      mem_wdata,
    output lc3b_word      mem_rdata,
    output logic          mem_resp,
    output logic          proto_err
);

    localparam int         AW         = $clog2(DEPTH_WORDS);
    localparam logic [3:0] c_CNT_INIT = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    dmem_state_t   r_state, w_next_state;
    logic [3:0]    r_cnt, w_cnt_next;
    logic [AW-1:0] r_addr;
    lc3b_word      r_wdata;
    lc3b_mem_wmask r_wmask;
    logic          r_is_write;
    lc3b_word      r_rdata;

    logic          w_req;
    logic          w_capture;
    logic          w_rd_op;
    logic [AW-1:0] w_rd_addr;
    lc3b_word      w_arr_rdata;
    logic          w_we;
    logic          w_unused_addr;

    assign w_req         = mem_read | mem_write;
    assign w_capture     = (r_state == IDLE) && w_req;
    assign w_unused_addr = ^{mem_address[15:AW+1], mem_address[0]};

    // With LATENCY==1 the read data must come from the live request, not the capture.
    assign w_rd_addr = (r_state == IDLE) ? mem_address[AW:1] : r_addr;
    assign w_rd_op   = (r_state == IDLE) ? !(mem_write && !mem_read) : !r_is_write;
    assign w_we      = (r_state == RESP) && r_is_write && !reset;

    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_next_state = (LATENCY == 1) ? RESP : WAIT;
                    w_cnt_next   = c_CNT_INIT;
                end
            end
            WAIT: begin
                if (!w_req) begin
                    w_next_state = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_next_state = RESP;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_is_write <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_capture) begin
                r_addr     <= mem_address[AW:1];
                r_wdata    <= mem_wdata;
                r_wmask    <= mem_byte_enable;
                r_is_write <= mem_write && !mem_read;
            end
            if ((w_next_state == RESP) && w_rd_op) begin
                r_rdata <= w_arr_rdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .i_we    (w_we),
        .i_wmask (r_wmask),
        .i_waddr (r_addr),
        .i_wdata (r_wdata),
        .i_raddr (w_rd_addr),
        .o_rdata (w_arr_rdata)
    );

    assign mem_rdata = r_rdata;
    assign mem_resp  = (r_state == RESP) && !reset;
    assign proto_err = (r_state == IDLE) && mem_read && mem_write && !reset;

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
//------------------------------------------------------------------------------
// Module : tb_dmem_responder
// Brief  : Self-checking bench for dmem_responder at LATENCY 3 and LATENCY 1.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        a_rst, a_rd, a_wr, a_resp, a_perr;
    logic [15:0] a_addr, a_wd, a_rdata;
    logic [1:0]  a_be;
    logic        b_rst, b_rd, b_wr, b_resp, b_perr;
    logic [15:0] b_addr, b_wd, b_rdata;
    logic [1:0]  b_be;

    logic [15:0] m_a [256];
    logic [15:0] m_b [256];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(3), .DEPTH_WORDS(256)) dut_a (
        .clk(clk), .reset(a_rst), .mem_address(a_addr), .mem_read(a_rd),
        .mem_write(a_wr), .mem_byte_enable(a_be), .mem_wdata(a_wd),
        .mem_rdata(a_rdata), .mem_resp(a_resp), .proto_err(a_perr)
    );

    dmem_responder #(.LATENCY(1), .DEPTH_WORDS(256)) dut_b (
        .clk(clk), .reset(b_rst), .mem_address(b_addr), .mem_read(b_rd),
        .mem_write(b_wr), .mem_byte_enable(b_be), .mem_wdata(b_wd),
        .mem_rdata(b_rdata), .mem_resp(b_resp), .proto_err(b_perr)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkint(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit rd, input bit wr,
                         input logic [15:0] addr, input logic [15:0] wd, input logic [1:0] be);
        if (sel) begin
            b_rd = rd; b_wr = wr; b_addr = addr; b_wd = wd; b_be = be;
        end else begin
            a_rd = rd; a_wr = wr; a_addr = addr; a_wd = wd; a_be = be;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that ends the response cycle.
    task automatic do_req(input bit sel, input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be, input string tag);
        int          lat;
        bit          got;
        logic [7:0]  idx;
        logic [15:0] exp_rd, old;
        logic        r, p;
        logic [15:0] d;
        lat    = sel ? 1 : 3;
        got    = 1'b0;
        idx    = addr[8:1];
        exp_rd = sel ? m_b[idx] : m_a[idx];
        drive(sel, rd, wr, addr, wd, be);
        for (int k = 0; k <= lat + 2 && !got; k++) begin
            @(negedge clk);
            r = sel ? b_resp  : a_resp;
            p = sel ? b_perr  : a_perr;
            d = sel ? b_rdata : a_rdata;
            if (k == 0) chk1({tag, "_proto_err"}, p, rd && wr);
            if (r) begin
                got = 1'b1;
                chkint({tag, "_latency"}, k, lat);
                if (rd) chk16({tag, "_rdata"}, d, exp_rd);
            end
            @(posedge clk); #1;
        end
        if (!got) chk1({tag, "_timeout"}, 1'b0, 1'b1);
        drive(sel, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        if (wr && !rd) begin
            old = exp_rd;
            if (be[0]) old[7:0]  = wd[7:0];
            if (be[1]) old[15:8] = wd[15:8];
            if (sel) m_b[idx] = old; else m_a[idx] = old;
        end
    endtask

    initial begin
        int          first, second, nresp, opsel;
        logic [15:0] v, ra, rw;
        logic [1:0]  rm;
        a_rst = 1'b1; b_rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

        for (int i = 0; i < 256; i++) begin
            v = 16'($urandom);
            m_a[i] = v; dut_a.u_array.load_word(i, v);
            v = 16'($urandom);
            m_b[i] = v; dut_b.u_array.load_word(i, v);
        end
        m_a[8'h10] = 16'hBEEF; dut_a.u_array.load_word(32'h10, 16'hBEEF);
        m_a[8'h20] = 16'h1234; dut_a.u_array.load_word(32'h20, 16'h1234);
        m_a[8'h80] = 16'h5A5A; dut_a.u_array.load_word(32'h80, 16'h5A5A);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk1("reset_resp_a", a_resp, 1'b0);
        chk1("reset_perr_a", a_perr, 1'b0);
        chk16("reset_rdata_a", a_rdata, 16'h0000);
        chk16("reset_rdata_b", b_rdata, 16'h0000);
        @(posedge clk); #1;
        a_rst = 1'b0; b_rst = 1'b0;

        do_req(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00, "read_beef");
        do_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'hABCD, 2'b10, "bytewr_hi");
        do_req(1'b0, 1'b1, 1'b0, 16'h0040, 16'h0, 2'b00, "bytewr_readback");
        chk16("bytewr_model", m_a[8'h20], 16'hAB34);
        do_req(1'b0, 1'b0, 1'b1, 16'h0040, 16'hFFFF, 2'b00, "wr_nomask");
        do_req(1'b0, 1'b1, 1'b0, 16'h0041, 16'h0, 2'b00, "nomask_readback");

        // LDI-style: pointer fetch, then the dereference with mem_read never dropped.
        m_a[8'h10] = 16'h0100;
        do_req(1'b0, 1'b0, 1'b1, 16'h0020, 16'h0100, 2'b11, "ldi_setup");
        first = -1; second = -1;
        drive(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0, 2'b00);
        for (int k = 0; k < 14 && second < 0; k++) begin
            @(negedge clk);
            if (a_resp) begin
                if (first < 0) begin
                    first = k;
                    chk16("ldi_ptr", a_rdata, 16'h0100);
                    a_addr = a_rdata;
                end else begin
                    second = k;
                    chk16("ldi_data", a_rdata, m_a[8'h80]);
                end
            end
        end
        chkint("ldi_first_lat", first, 3);
        chkint("ldi_gap", second - first, 4);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);

        // Abort: drop the request while in WAIT.
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0, 2'b00);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        nresp = 0;
        repeat (6) begin
            @(negedge clk);
            if (a_resp) nresp++;
        end
        chkint("abort_no_resp", nresp, 0);
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 1'b0, 16'h0012, 16'h0, 2'b00, "after_abort");

        do_req(1'b0, 1'b1, 1'b1, 16'h0022, 16'h7777, 2'b11, "proto");
        do_req(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0, 2'b00, "proto_unchanged");

        // Reset lands in the RESP cycle of a write: the write must be dropped.
        drive(1'b0, 1'b0, 1'b1, 16'h0060, 16'hFFFF, 2'b11);
        repeat (3) begin @(posedge clk); #1; end
        a_rst = 1'b1;
        @(negedge clk);
        chk1("rst_resp_cycle", a_resp, 1'b0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
        @(negedge clk);
        chk1("rst_after_resp", a_resp, 1'b0);
        chk16("rst_after_rdata", a_rdata, 16'h0000);
        @(posedge clk); #1;
        do_req(1'b0, 1'b1, 1'b0, 16'h0060, 16'h0, 2'b00, "rst_old_data");

        for (int i = 0; i < 40; i++) begin
            opsel = $urandom_range(0, 7);
            ra = 16'($urandom);
            ra[8] = 1'b1;
            ra[7] = 1'b0;
            rw = 16'($urandom);
            rm = 2'($urandom);
            do_req(i[0], opsel < 4 || opsel == 7, opsel >= 4, ra, rw, rm,
                   i[0] ? "rand_l1" : "rand_l3");
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end

        do_req(1'b1, 1'b0, 1'b1, 16'h0006, 16'hC0DE, 2'b01, "l1_write");
        do_req(1'b1, 1'b1, 1'b0, 16'h0006, 16'h0, 2'b00, "l1_readback");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
